// File: rtl/sevenseg_pkg.sv
// Shared types and default constants for the 7-segment digit scanner.
// Contents:
//   nibble_t          - one hex digit as presented to the segment decoder
//   SEVENSEG_DIGITS   - default number of multiplexed digits
//   SEVENSEG_TICK_DIV - default clock cycles per digit slot
package sevenseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int SEVENSEG_DIGITS   = 4;
  localparam int SEVENSEG_TICK_DIV = 50000;

endpackage : sevenseg_pkg

// File: rtl/scan_tick.sv
// Slot prescaler for the digit scanner. It counts clock cycles modulo
// TICK_DIV and raises tick_o for exactly one cycle while the count sits
// at its last value (TICK_DIV-1), which is the final cycle of a slot.
// tick_o comes from a flop that is loaded with the comparison against
// the next count value, so it stays aligned with the counter.
// Ports:
//   clk_i  - system clock
//   rst_ni - synchronous active-low reset (count restarts at 0)
//   tick_o - one-cycle pulse in the last cycle of each slot
module scan_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;

  // Next count value, wrapping after the last cycle of the slot.
  always_comb begin
    cnt_nxt_s = '0;
    if (cnt_r == LAST) begin
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // Count register and registered slot-end flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_r  <= '0;
      // With a one-cycle slot every cycle is a slot end, including the first.
      tick_r <= (LAST == '0);
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == LAST);
    end
  end

  assign tick_o = tick_r;

endmodule : scan_tick

// File: rtl/sevenseg_scan.sv
// Time-multiplexed digit scanner feeding a 7-segment decoder.
// A staging buffer captures value_i/dp_i on load_i; the display buffer
// only takes the staged content at a frame wrap, so a frame never shows
// a mix of old and new digits. One nibble per slot is presented on bin_o
// with one-hot digit enables; all outputs are registered.
// Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking
// (digits above the most significant non-zero nibble get no enable,
// except digit 0 and any digit whose decimal point is set).
// Ports:
//   clk_i       - system clock
//   rst_ni      - synchronous active-low reset
//   value_i     - 4*DIGITS hex value, nibble k = digit k
//   dp_i        - decimal point per digit
//   load_i      - capture value_i/dp_i into the staging buffer
//   bin_o       - nibble of the active digit (to decoder bin_i)
//   dp_o        - decimal point of the active digit
//   digit_en_o  - one-hot active-high digit enable
//   digit_enn_o - bitwise inverse of digit_en_o
//   frame_o     - one-cycle pulse at the start of each digit-0 slot after a wrap
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS   = SEVENSEG_DIGITS,
  parameter int TICK_DIV = SEVENSEG_TICK_DIV
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  load_i,
  output logic [3:0]            bin_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic [DIGITS-1:0]     digit_enn_o,
  output logic                  frame_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic                tick_s;
  logic                wrap_s;
  logic [IW-1:0]       idx_r;
  logic [IW-1:0]       idx_nxt_s;

  logic [4*DIGITS-1:0] stg_val_r;
  logic [DIGITS-1:0]   stg_dp_r;
  logic                pending_r;
  logic [4*DIGITS-1:0] disp_val_r;
  logic [DIGITS-1:0]   disp_dp_r;

  logic [4*DIGITS-1:0] disp_val_nxt_s;
  logic [DIGITS-1:0]   disp_dp_nxt_s;
  nibble_t             nib_s;
  logic                dp_s;
  logic                blank_s;
  logic [DIGITS-1:0]   en_s;

  logic [3:0]          bin_r;
  logic                dp_r;
  logic [DIGITS-1:0]   en_r;
  logic                frame_r;

  scan_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_scan_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick_s)
  );

  // Slot sequencing: next digit index and frame wrap detection.
  always_comb begin
    wrap_s    = 1'b0;
    idx_nxt_s = idx_r;
    if (tick_s) begin
      if (idx_r == IDX_LAST) begin
        wrap_s    = 1'b1;
        idx_nxt_s = '0;
      end else begin
        wrap_s    = 1'b0;
        idx_nxt_s = idx_r + IW'(1);
      end
    end else begin
      wrap_s    = 1'b0;
      idx_nxt_s = idx_r;
    end
  end

  // Display content as it will be after this edge, so the outputs
  // loaded at a wrap already show the freshly swapped frame.
  always_comb begin
    disp_val_nxt_s = disp_val_r;
    disp_dp_nxt_s  = disp_dp_r;
    if (wrap_s && pending_r) begin
      disp_val_nxt_s = stg_val_r;
      disp_dp_nxt_s  = stg_dp_r;
    end else begin
      disp_val_nxt_s = disp_val_r;
      disp_dp_nxt_s  = disp_dp_r;
    end
  end

  // Select the nibble/dp of the upcoming digit and decide its enable.
  always_comb begin
    nib_s   = 4'h0;
    dp_s    = 1'b0;
    blank_s = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx_nxt_s) begin
        nib_s = disp_val_nxt_s[4*k +: 4];
        dp_s  = disp_dp_nxt_s[k];
      end else begin
        nib_s = nib_s;
        dp_s  = dp_s;
      end
    end
`ifdef SEVENSEG_LZB_EN
    // Blank when this digit and every digit above it are zero, unless
    // it is digit 0 or carries a decimal point.
    blank_s = (idx_nxt_s != '0) && !dp_s;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(idx_nxt_s)) && (disp_val_nxt_s[4*k +: 4] != 4'h0)) begin
        blank_s = 1'b0;
      end else begin
        blank_s = blank_s;
      end
    end
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      en_s = '0;
    end else begin
      en_s = DIGITS'(1) << idx_nxt_s;
    end
  end

  // Scan state, double buffer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_r      <= '0;
      stg_val_r  <= '0;
      stg_dp_r   <= '0;
      pending_r  <= 1'b0;
      disp_val_r <= '0;
      disp_dp_r  <= '0;
      bin_r      <= 4'h0;
      dp_r       <= 1'b0;
      en_r       <= DIGITS'(1);
      frame_r    <= 1'b0;
    end else begin
      idx_r      <= idx_nxt_s;
      disp_val_r <= disp_val_nxt_s;
      disp_dp_r  <= disp_dp_nxt_s;
      frame_r    <= wrap_s;
      // A load coinciding with a wrap stays pending for the next frame.
      if (load_i) begin
        stg_val_r <= value_i;
        stg_dp_r  <= dp_i;
        pending_r <= 1'b1;
      end else if (wrap_s) begin
        pending_r <= 1'b0;
      end
      if (tick_s) begin
        bin_r <= nib_s;
        dp_r  <= dp_s;
        en_r  <= en_s;
      end
    end
  end

  assign bin_o       = bin_r;
  assign dp_o        = dp_r;
  assign digit_en_o  = en_r;
  assign digit_enn_o = ~en_r;
  assign frame_o     = frame_r;

endmodule : sevenseg_scan

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with DIGITS=4, TICK_DIV=4.
// A cycle-count reference model pushes the expected output word for
// every clock edge into a queue; the word is popped and compared with
// the DUT outputs 1 ns after that edge. Honours SEVENSEG_LZB_EN.
module tb_sevenseg_scan;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int FRAME    = DIGITS * TICK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  bin_o;
  logic        dp_o;
  logic [3:0]  digit_en_o;
  logic [3:0]  digit_enn_o;
  logic        frame_o;

  always #5 clk = ~clk;

  sevenseg_scan #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .value_i     (value),
    .dp_i        (dp_in),
    .load_i      (load),
    .bin_o       (bin_o),
    .dp_o        (dp_o),
    .digit_en_o  (digit_en_o),
    .digit_enn_o (digit_enn_o),
    .frame_o     (frame_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;

  logic [13:0] exp_q[$];

  // Reference model: cycles since reset, staging and display buffers.
  int          m_t = 0;
  logic [15:0] m_stg = 16'h0;
  logic [3:0]  m_stg_dp = 4'h0;
  logic        m_pend = 1'b0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_disp_dp = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  // Expected {bin, dp, en, enn, frame} for the current model state.
  function automatic logic [13:0] model_word();
    int          digit;
    logic [3:0]  nib;
    logic [3:0]  en;
    logic        dpv;
    logic        frm;
    logic [15:0] upper;
    digit = (m_t / TICK_DIV) % DIGITS;
    upper = m_disp >> (4 * digit);
    nib   = upper[3:0];
    dpv   = m_disp_dp[digit];
    en    = 4'b0001 << digit;
`ifdef SEVENSEG_LZB_EN
    if (digit != 0 && !dpv && upper == 16'h0) en = 4'b0000;
`endif
    frm = (m_t > 0) && (m_t % FRAME == 0);
    return {nib, dpv, en, ~en, frm};
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_t = 0; m_stg = 16'h0; m_stg_dp = 4'h0; m_pend = 1'b0;
      m_disp = 16'h0; m_disp_dp = 4'h0;
    end else begin
      m_t++;
      if ((m_t % FRAME == 0) && m_pend) begin
        m_disp = m_stg; m_disp_dp = m_stg_dp; m_pend = 1'b0;
      end
      if (load) begin
        m_stg = value; m_stg_dp = dp_in; m_pend = 1'b1;
      end
    end
    exp_q.push_back(model_word());
  endtask

  task automatic step(input string tag);
    logic [13:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, {18'h0, bin_o, dp_o, digit_en_o, digit_enn_o, frame_o}, {18'h0, exp});
    end
    if (frame_o) frame_cnt++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d, input string tag);
    load = 1'b1; value = v; dp_in = d;
    step(tag);
    load = 1'b0;
  endtask

  // Advance until the model phase within the frame equals the target.
  task automatic advance_to(input int phase);
    for (int i = 0; i < FRAME; i++) begin
      if (m_t % FRAME == phase) break;
      step("advance");
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0; dp_in = 4'h0;
    #2;
    run(2, "reset");
    check_eq("reset_en", {28'h0, digit_en_o}, 32'h1);
    check_eq("reset_enn", {28'h0, digit_enn_o}, 32'hE);

    rst_n = 1'b1;
    load_once(16'h12A7, 4'b0100, "load_12a7");
    run(40, "show_12a7");

    frame_cnt = 0;
    run(64, "freerun");
    check_eq("frame_count_64", frame_cnt, 32'd4);

    advance_to(2);
    load_once(16'h1234, 4'h0, "load_1234");
    run(4, "mid_frame");
    load_once(16'h5678, 4'h0, "load_5678");
    run(40, "show_5678");

    advance_to(3);
    load_once(16'h1111, 4'h0, "load_1111");
    advance_to(15);
    load_once(16'h9ABC, 4'b0001, "load_at_wrap");
    run(36, "after_wrap_load");

    load_once(16'h0030, 4'h0, "load_0030");
    run(40, "show_0030");
    load_once(16'h0030, 4'b1000, "load_0030_dp3");
    run(40, "show_0030_dp3");
    load_once(16'h0000, 4'h0, "load_zero");
    run(40, "show_zero");

    advance_to(9);
    load_once(16'hBEEF, 4'hF, "load_beef");
    rst_n = 1'b0;
    step("mid_reset");
    rst_n = 1'b1;
    run(40, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sevenseg_scan

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed digit scanner sitting directly upstream of the 7-segment decoder. It holds a multi-digit hex value in a tear-free double buffer, cycles through the digits at a programmable rate, and presents one 4-bit nibble per slot on `bin_o` together with one-hot digit enables and a decimal point. The decoder converts `bin_o` to segments; this block owns scan timing, buffering and blanking.

## Interface
- `DIGITS`, 4, number of multiplexed digits, legal 1..8
- `TICK_DIV`, 50000, clock cycles per digit slot, legal >= 1
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  synchronous reset, active-low
- `value_i`  in  4*DIGITS  hex value, nibble k = digit k (digit 0 = LSB)
- `dp_i`  in  DIGITS  decimal point per digit
- `load_i`  in  1  capture `value_i`/`dp_i` into staging buffer this cycle
- `bin_o`  out  4  nibble of active digit, feeds decoder `bin_i`
- `dp_o`  out  1  decimal point of active digit
- `digit_en_o`  out  DIGITS  one-hot active-high digit enable
- `digit_enn_o`  out  DIGITS  bitwise inverse of `digit_en_o`
- `frame_o`  out  1  one-cycle pulse at start of each frame (digit 0 slot)

## Operation
- Registers: slot counter `cnt` (0..TICK_DIV-1), digit index `idx` (0..DIGITS-1), staging value/dp + `pending` flag, display value/dp, all outputs registered.
- Reset (`rst_ni`=0 at edge): cnt=0, idx=0, staging=display=0, pending=0, `bin_o`=0, `dp_o`=0, `digit_en_o`=…0001, `digit_enn_o`=…1110, `frame_o`=0.
- `load_i`=1: staging <= `value_i`/`dp_i`, pending <= 1. Multiple loads in one frame: last wins.
- Slot end (cnt==TICK_DIV-1): cnt <= 0, idx <= idx+1, wraps DIGITS-1 -> 0; else cnt <= cnt+1.
- Frame wrap (slot end with idx==DIGITS-1): if pending, display <= staging and pending <= 0; `frame_o` <= 1 for one cycle.
- Simultaneous `load_i` and frame wrap: display takes the old staging content; staging takes new `value_i`; pending stays 1 (shown next frame).
- Display buffer never changes mid-frame: no tearing.
- Outputs on every slot-end edge reflect the new idx and post-update display: `bin_o` = display nibble[new idx], `dp_o` = display dp[new idx], `digit_en_o` = 1 << new idx.
- DIGITS=1: idx constant 0, `digit_en_o`=1, `frame_o` pulses every TICK_DIV cycles.
- TICK_DIV=1: idx advances every cycle.

## Timing
- Each digit slot lasts exactly TICK_DIV cycles; frame = DIGITS*TICK_DIV cycles.
- First slot after reset release: digit 0 for TICK_DIV cycles, no `frame_o` pulse for this partial frame.
- `frame_o` high exactly in the first cycle of every digit-0 slot after a wrap.
- Load-to-display latency: 1 to DIGITS*TICK_DIV cycles (next frame wrap after capture).
- Counter width max(1, $clog2(TICK_DIV)); idx width max(1, $clog2(DIGITS)).
- Reset mid-frame: next cycle in reset state; pending load discarded.

## Configuration
- `SEVENSEG_LZB_EN` defined: leading-zero blanking. Digits above the most significant non-zero nibble of the display buffer get `digit_en_o` all-zero (`digit_enn_o` all-one) for their slot; slot timing and `frame_o` unchanged; digit 0 never blanked; a digit with `dp` set is never blanked.
- Undefined: every digit enabled in its slot, zeros shown.

## Structure
- Package `sevenseg_pkg`: `nibble_t` (logic [3:0]), default constants `SEVENSEG_DIGITS`=4, `SEVENSEG_TICK_DIV`=50000.
- Sub-module `scan_tick`: prescaler, parameter TICK_DIV, outputs one-cycle `tick_o` on cnt==TICK_DIV-1; synchronous active-low reset.
- Decoder instantiated by the parent, not inside this block.

## Test plan (DIGITS=4, TICK_DIV=4)
- Hold `rst_ni`=0 2 cycles -> `digit_en_o`=0001, `digit_enn_o`=1110, `bin_o`=0, `dp_o`=0, `frame_o`=0.
- Load 16'h12A7, dp 4'b0100 -> after next wrap, `bin_o` 7,A,2,1 for 4 cycles each, `dp_o`=1 only in digit-2 slot.
- Free run 64 cycles -> `frame_o` one-cycle pulse every 16 cycles, aligned with `digit_en_o`=0001.
- Load 16'h1234 then 16'h5678 mid-frame -> current frame keeps old value; next frame shows 8,7,6,5 throughout.
- `SEVENSEG_LZB_EN`: load 16'h0030 -> digit 3/2 slots `digit_en_o`=0000, digits 1/0 show 3,0; without macro 0,3,0,0 order d0..d3 all enabled; load 0 -> only digit 0 enabled.
- Assert `rst_ni`=0 during digit-2 slot with pending load -> next cycle reset state; display stays 0 after following frame.
